// File: rtl/vga_ram_pkg.sv
// rtl/vga_ram_pkg.sv - shared encodings and default widths for the VGA frame RAM arbiter
package vga_ram_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_WBUF_DEPTH    = 4;
    localparam int DEF_STALL_LIMIT   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DATA  = 2'd3
    } rd_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        WBUF = 2'd2,
        CRD  = 2'd3
    } owner_t;

endpackage

// File: rtl/vga_wbuf_fifo.sv
// rtl/vga_wbuf_fifo.sv - synchronous FIFO holding posted CPU writes {addr, data}
module vga_wbuf_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/vga_ram_arbiter.sv
// rtl/vga_ram_arbiter.sv - shares one single-port frame RAM between display scanout and CPU
module vga_ram_arbiter
    import vga_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int WBUF_DEPTH    = DEF_WBUF_DEPTH,
    parameter int STALL_LIMIT   = DEF_STALL_LIMIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     disp_req,
    input  logic [ADDRESS_WIDTH-1:0] disp_addr,
    output logic                     disp_valid,
    output logic [DATA_WIDTH-1:0]    disp_data,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_ready,
    output logic                     cpu_rvalid,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     disp_stalled,
    output logic                     ram_wEn,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

    localparam int SW = $clog2(STALL_LIMIT + 1);

    rd_state_t                state, state_next;
    owner_t                   grant;
    logic [SW-1:0]            stall_cnt;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic                     wbuf_full, wbuf_empty, wbuf_push, wbuf_pop;
    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]    head_data;
    logic                     cpu_work, forced;

    vga_wbuf_fifo #(
        .WIDTH (ADDRESS_WIDTH + DATA_WIDTH),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .reset     (reset),
        .push      (wbuf_push),
        .push_data ({cpu_addr, cpu_wdata}),
        .pop       (wbuf_pop),
        .full      (wbuf_full),
        .empty     (wbuf_empty),
        .head      ({head_addr, head_data})
    );

    assign cpu_work  = !wbuf_empty || (state != IDLE);
    // A forced slot is only taken when there is something the CPU side can issue now.
    assign forced    = !reset && (stall_cnt == SW'(STALL_LIMIT))
                       && ((state == RD_ISSUE) || !wbuf_empty);
    assign cpu_ready = !reset && cpu_req && (state == IDLE) && (!cpu_we || !wbuf_full);
    assign wbuf_push = cpu_ready && cpu_we;
    assign wbuf_pop  = (grant == WBUF);

    always_comb begin
        grant = NONE;
        if (!reset) begin
            if (forced) begin
                grant = (state == RD_ISSUE) ? CRD : WBUF;
            end else if (disp_req) begin
                grant = DISP;
            end else if (state == RD_ISSUE) begin
                grant = CRD;
            end else if (!wbuf_empty) begin
                grant = WBUF;
            end
        end
    end

    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = disp_addr;
        ram_dataIn = head_data;
        case (grant)
            WBUF: begin
                ram_wEn  = 1'b1;
                ram_addr = head_addr;
            end
            CRD:     ram_addr = rd_addr;
            default: ram_addr = disp_addr;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (cpu_ready && !cpu_we) state_next = RD_WAIT;
            RD_WAIT:  if (wbuf_empty) state_next = RD_ISSUE;
            RD_ISSUE: if (grant == CRD) state_next = RD_DATA;
            RD_DATA:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            stall_cnt  <= '0;
            rd_addr    <= '0;
            disp_valid <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            state      <= state_next;
            disp_valid <= (grant == DISP);
            cpu_rvalid <= (state == RD_DATA);
            if (state == RD_DATA) begin
                cpu_rdata <= ram_dataOut;
            end
            if (cpu_ready && !cpu_we) begin
                rd_addr <= cpu_addr;
            end
            if ((grant == WBUF) || (grant == CRD) || !cpu_work) begin
                stall_cnt <= '0;
            end else if ((grant == DISP) && (stall_cnt != SW'(STALL_LIMIT))) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign disp_data    = ram_dataOut;
    assign disp_stalled = forced && disp_req;

endmodule

// File: doc/vga_ram_arbiter.md
Name: vga_ram_arbiter

Overview:
- Shares one single-port VGA frame RAM (1-cycle registered read; a write cycle performs no read) between two requesters.
- Display scanout read port: fixed top priority, guaranteed 1-cycle latency.
- CPU port: posted writes through a small write buffer; reads are ordered behind pending writes.
- Sits between the VGA timing/pixel fetch logic, the CPU memory-mapped I/O decode and the frame RAM instance.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDRESS_WIDTH, 8, RAM address width.
- WBUF_DEPTH, 4, CPU write-buffer entries; power of 2, minimum 2.
- STALL_LIMIT, 16, consecutive display-blocked cycles before a CPU slot is forced.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- disp_req  in  1  display read request this cycle.
- disp_addr  in  ADDRESS_WIDTH  display read address.
- disp_valid  out  1  disp_data valid; one cycle after an accepted disp_req.
- disp_data  out  DATA_WIDTH  display read data.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDRESS_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ready  out  1  CPU request accepted this cycle.
- cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
- cpu_rdata  out  DATA_WIDTH  CPU read data, held until next cpu_rvalid.
- disp_stalled  out  1  a disp_req was dropped this cycle (forced CPU slot).
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDRESS_WIDTH  RAM address.
- ram_dataIn  out  DATA_WIDTH  RAM write data.
- ram_dataOut  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- RAM signals are combinational from the current-cycle grant. Exactly one owner per cycle: DISP, WBUF drain, CPU read, or none. With no owner, ram_wEn=0 and ram_addr=disp_addr.
- Grant priority:
  - forced CPU slot (stall_cnt == STALL_LIMIT);
  - otherwise disp_req;
  - otherwise CPU read in RD_ISSUE;
  - otherwise WBUF drain if the buffer is non-empty.
  - A forced slot goes to RD_ISSUE if in that state, else to WBUF drain. No slot is forced if there is no CPU work.
- stall_cnt increments each cycle disp_req is granted while CPU work is pending (wbuf non-empty or state != IDLE). It clears on any CPU grant or when no work is pending. Saturates at STALL_LIMIT.
- Display: disp_valid is disp_req registered and suppressed on forced cycles; disp_data = ram_dataOut. disp_stalled=1 on a forced cycle that also has disp_req. Dropped requests are not replayed.
- CPU write:
  - cpu_ready = cpu_req & cpu_we & !wbuf_full & state==IDLE; the write is pushed to the FIFO.
  - A push and a drain may occur in the same cycle: count unchanged.
  - Drain writes the oldest entry in FIFO order.
- CPU read FSM (registered states):
  - IDLE: on cpu_req & !cpu_we, pulse cpu_ready, latch the address, go to RD_WAIT.
  - RD_WAIT: wait for wbuf empty (read-after-write ordering), then go to RD_ISSUE.
  - RD_ISSUE: on a CPU grant, go to RD_DATA.
  - RD_DATA: capture ram_dataOut into cpu_rdata, pulse cpu_rvalid, go to IDLE.
  - While state != IDLE, no new CPU request is accepted.
- Reset: state=IDLE, FIFO pointers/count=0, stall_cnt=0.
  - disp_valid, cpu_ready, cpu_rvalid, disp_stalled, ram_wEn = 0.
  - cpu_rdata=0 and disp_data passthrough.
  - Reset mid-read drops the read; no cpu_rvalid is generated.
  - Reset discards buffered writes; they are never written.
- Address and data widths pass through unchanged; no arithmetic on data.

Decomposition:
- Shared package vga_ram_pkg holds:
  - the FSM state encoding (IDLE, RD_WAIT, RD_ISSUE, RD_DATA);
  - the grant-owner encoding (NONE, DISP, WBUF, CRD);
  - default widths.
- One sub-module: vga_wbuf_fifo. Synchronous FIFO with push/pop/full/empty/head outputs, width ADDRESS_WIDTH+DATA_WIDTH, depth WBUF_DEPTH, same clk/reset.

Test Plan:
- Display only: disp_req every cycle, addr 0..255, RAM preloaded with addr^8'hA5 -> disp_valid every cycle one cycle late, data matches, ram_wEn never 1.
- Posted writes, display idle: 4 writes (addr 10..13, data 1..4) -> cpu_ready each cycle, RAM writes in order one per cycle; fifth write while full -> cpu_ready=0 until a drain.
- Read-after-write: write addr 20=8'h5A then read addr 20 with disp_req held continuously -> write drains on the forced slot, read issues on the next forced slot, cpu_rvalid with 8'h5A.
- Starvation: disp_req constant, one buffered write -> write lands exactly at cycle STALL_LIMIT+1 after push, disp_stalled=1 that cycle, no disp_valid the following cycle.
- Simultaneous push/drain with wbuf at 3 -> count stays 3, no entry lost or reordered.
- Reset asserted in RD_DATA and with 2 buffered writes -> no cpu_rvalid, RAM unchanged at those addresses, all outputs 0 the next cycle.
